// File: rtl/edf_gw_pkg.sv
// Shared types and default sizing for the EDF interrupt gateway.
// Optional deadline-miss flags are enabled with EDF_GW_DL_MISS_EN.
package edf_gw_pkg;

  localparam int DefNrSrc    = 8;
  localparam int DefTsWidth  = 64;
  localparam int DefOffWidth = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACT  = 2'd2
  } gw_state_e;

  typedef logic [DefTsWidth-1:0] deadline_t;

endpackage

// File: rtl/edf_gateway_if.sv
// Bundle of IRQ, configuration, handshake and result signals of the gateway.
// dl_miss_o exists only when EDF_GW_DL_MISS_EN is defined.
interface edf_gateway_if
  import edf_gw_pkg::*;
#(
  parameter int NrSrc    = DefNrSrc,
  parameter int TsWidth  = DefTsWidth,
  parameter int OffWidth = DefOffWidth
);

  localparam int IdxW = $clog2(NrSrc);

  logic [NrSrc-1:0]         irq_i;
  logic [NrSrc-1:0]         edge_i;
  logic [NrSrc-1:0]         ie_i;
  logic                     off_we_i;
  logic [IdxW-1:0]          off_idx_i;
  logic [OffWidth-1:0]      off_wdata_i;
  logic                     claim_i;
  logic [IdxW-1:0]          claim_idx_i;
  logic                     complete_i;
  logic [IdxW-1:0]          complete_idx_i;
  logic [NrSrc-1:0]         ip_o;
  logic [NrSrc-1:0]         act_o;
  logic [NrSrc*TsWidth-1:0] dl_o;
  logic [2*NrSrc-1:0]       state_dbg;
`ifdef EDF_GW_DL_MISS_EN
  logic [NrSrc-1:0]         dl_miss_o;
`endif

  // Strobes (off_we_i, claim_i, complete_i) are single-cycle commands, sampled
  // on each rising clk edge; there is no backpressure in either direction.
  modport slave (
    input  irq_i, edge_i, ie_i, off_we_i, off_idx_i, off_wdata_i,
    input  claim_i, claim_idx_i, complete_i, complete_idx_i,
    output ip_o, act_o, dl_o, state_dbg
`ifdef EDF_GW_DL_MISS_EN
    , output dl_miss_o
`endif
  );

  modport master (
    output irq_i, edge_i, ie_i, off_we_i, off_idx_i, off_wdata_i,
    output claim_i, claim_idx_i, complete_i, complete_idx_i,
    input  ip_o, act_o, dl_o, state_dbg
`ifdef EDF_GW_DL_MISS_EN
    , input dl_miss_o
`endif
  );

endinterface

// File: rtl/edf_gw_cell.sv
// One gateway source: trigger detect, IDLE/PEND/ACT FSM, offset and deadline.
// EDF_GW_DL_MISS_EN adds a sticky deadline-miss flag.
module edf_gw_cell
  import edf_gw_pkg::*;
#(
  parameter int TsWidth  = DefTsWidth,
  parameter int OffWidth = DefOffWidth
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [TsWidth-1:0]  mtime,
  input  logic                irq,
  input  logic                edge_mode,
  input  logic                ie,
  input  logic                off_we,
  input  logic [OffWidth-1:0] off_wdata,
  input  logic                claim,
  input  logic                complete,
  output logic                ip,
  output logic                act,
  output logic [TsWidth-1:0]  dl,
  output gw_state_e           state
`ifdef EDF_GW_DL_MISS_EN
  ,
  output logic                dl_miss
`endif
);

  gw_state_e           state_q, state_d;
  logic                irq_prev_q;
  logic [OffWidth-1:0] offset_q;
  logic [TsWidth-1:0]  dl_q;
  logic                trig, req, capture;

  assign trig    = edge_mode ? (irq & ~irq_prev_q) : irq;
  assign req     = trig & ie;
  assign capture = (state_d == PEND) && (state_q != PEND);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = PEND;
      PEND:    if (claim && ie) state_d = ACT;
      ACT:     if (complete) state_d = req ? PEND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      irq_prev_q <= 1'b0;
      offset_q   <= '0;
      dl_q       <= '0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq;
      // Captured with the pre-write offset so a same-cycle write only affects later triggers.
      if (capture) dl_q <= mtime + TsWidth'(offset_q);
      if (off_we) offset_q <= off_wdata;
    end
  end

  assign ip    = (state_q == PEND) & ie;
  assign act   = (state_q == ACT);
  assign dl    = dl_q;
  assign state = state_q;

`ifdef EDF_GW_DL_MISS_EN
  logic                miss_q;
  logic [TsWidth-1:0]  slack;

  // Sign of the modular difference gives a wrap-safe "mtime has reached dl" test.
  assign slack = mtime - dl_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miss_q <= 1'b0;
    end else if ((state_d == IDLE) || capture) begin
      miss_q <= 1'b0;
    end else if ((state_q != IDLE) && !slack[TsWidth-1]) begin
      miss_q <= 1'b1;
    end
  end

  assign dl_miss = miss_q;
`endif

endmodule

// File: rtl/edf_gateway.sv
// EDF interrupt gateway top: decodes indexed strobes and replicates one cell per source.
// EDF_GW_DL_MISS_EN enables the per-source dl_miss_o output.
module edf_gateway
  import edf_gw_pkg::*;
#(
  parameter int NrSrc    = DefNrSrc,
  parameter int TsWidth  = DefTsWidth,
  parameter int OffWidth = DefOffWidth
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [63:0]   mtime_i,
  edf_gateway_if.slave  bus
);

  localparam int IdxW = $clog2(NrSrc);

  logic [NrSrc-1:0]         ip_v;
  logic [NrSrc-1:0]         act_v;
  logic [NrSrc*TsWidth-1:0] dl_v;
  logic [2*NrSrc-1:0]       st_v;
  logic [TsWidth-1:0]       mtime_ts;
`ifdef EDF_GW_DL_MISS_EN
  logic [NrSrc-1:0]         miss_v;
`endif

  assign mtime_ts = mtime_i[TsWidth-1:0];

  for (genvar i = 0; i < NrSrc; i++) begin : g_src
    logic      off_hit, claim_hit, complete_hit;
    gw_state_e cell_state;

    // Comparing against each legal index leaves out-of-range indices with no target.
    assign off_hit      = bus.off_we_i   && (bus.off_idx_i      == IdxW'(i));
    assign claim_hit    = bus.claim_i    && (bus.claim_idx_i    == IdxW'(i));
    assign complete_hit = bus.complete_i && (bus.complete_idx_i == IdxW'(i));

    edf_gw_cell #(
      .TsWidth  (TsWidth),
      .OffWidth (OffWidth)
    ) u_cell (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .mtime     (mtime_ts),
      .irq       (bus.irq_i[i]),
      .edge_mode (bus.edge_i[i]),
      .ie        (bus.ie_i[i]),
      .off_we    (off_hit),
      .off_wdata (bus.off_wdata_i),
      .claim     (claim_hit),
      .complete  (complete_hit),
      .ip        (ip_v[i]),
      .act       (act_v[i]),
      .dl        (dl_v[i*TsWidth +: TsWidth]),
      .state     (cell_state)
`ifdef EDF_GW_DL_MISS_EN
      ,
      .dl_miss   (miss_v[i])
`endif
    );

    assign st_v[2*i +: 2] = cell_state;
  end

  assign bus.ip_o      = ip_v;
  assign bus.act_o     = act_v;
  assign bus.dl_o      = dl_v;
  assign bus.state_dbg = st_v;
`ifdef EDF_GW_DL_MISS_EN
  assign bus.dl_miss_o = miss_v;
`endif

endmodule

// File: tb/tb_edf_gateway.sv
// Self-checking bench for edf_gateway: directed scenarios then random traffic vs a reference model.
// Miss-flag checks are active when EDF_GW_DL_MISS_EN is defined.
module tb_edf_gateway;
  import edf_gw_pkg::*;

  localparam int N  = 6;
  localparam int TW = 64;
  localparam int OW = 32;
  localparam int IW = $clog2(N);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] mtime = '0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 0 = idle, 1 = waiting for claim, 2 = being serviced.
  int          md_st   [N];
  deadline_t   md_dl   [N];
  logic [OW-1:0] md_off [N];
  logic        md_prev [N];
  logic        md_miss [N];

  edf_gateway_if #(.NrSrc(N), .TsWidth(TW), .OffWidth(OW)) bus ();

  edf_gateway #(.NrSrc(N), .TsWidth(TW), .OffWidth(OW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .mtime_i (mtime),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dl_of(input int i);
    logic [N*TW-1:0] flat;
    flat = bus.dl_o;
    return flat[i*TW +: TW];
  endfunction

  task automatic model_tick();
    logic [63:0] diff;
    logic        trig, req;
    int          nxt;
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        md_st[i] = 0; md_dl[i] = '0; md_off[i] = '0; md_prev[i] = 1'b0; md_miss[i] = 1'b0;
        continue;
      end
      trig = bus.edge_i[i] ? (bus.irq_i[i] & ~md_prev[i]) : bus.irq_i[i];
      req  = trig & bus.ie_i[i];
      diff = mtime - md_dl[i];
      if (md_st[i] != 0 && !diff[63]) md_miss[i] = 1'b1;
      nxt = md_st[i];
      if (md_st[i] == 0 && req) nxt = 1;
      else if (md_st[i] == 1 && bus.claim_i && int'(bus.claim_idx_i) == i && bus.ie_i[i]) nxt = 2;
      else if (md_st[i] == 2 && bus.complete_i && int'(bus.complete_idx_i) == i) nxt = req ? 1 : 0;
      if (nxt == 1 && md_st[i] != 1) begin
        md_dl[i]   = mtime + 64'(md_off[i]);
        md_miss[i] = 1'b0;
      end
      if (nxt == 0) md_miss[i] = 1'b0;
      md_st[i] = nxt;
      if (bus.off_we_i && int'(bus.off_idx_i) == i) md_off[i] = bus.off_wdata_i;
      md_prev[i] = bus.irq_i[i];
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] ip_e, act_e, miss_e;
    for (int i = 0; i < N; i++) begin
      ip_e[i]   = (md_st[i] == 1) && bus.ie_i[i];
      act_e[i]  = (md_st[i] == 2);
      miss_e[i] = md_miss[i];
      check($sformatf("dl[%0d]", i), dl_of(i), md_dl[i]);
    end
    check("ip", 64'(bus.ip_o), 64'(ip_e));
    check("act", 64'(bus.act_o), 64'(act_e));
`ifdef EDF_GW_DL_MISS_EN
    check("miss", 64'(bus.dl_miss_o), 64'(miss_e));
`else
    if (miss_e == '1) ;  // miss model unused without the feature
`endif
  endtask

  // One clock: model and DUT advance on the same edge, outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    compare_all();
    bus.claim_i    = 1'b0;
    bus.complete_i = 1'b0;
    bus.off_we_i   = 1'b0;
  endtask

  task automatic wr_off(input int idx, input int val);
    bus.off_we_i = 1'b1; bus.off_idx_i = IW'(idx); bus.off_wdata_i = OW'(val);
    step();
  endtask

  task automatic do_claim(input int idx);
    bus.claim_i = 1'b1; bus.claim_idx_i = IW'(idx);
    step();
  endtask

  task automatic do_complete(input int idx);
    bus.complete_i = 1'b1; bus.complete_idx_i = IW'(idx);
    step();
  endtask

  initial begin
    bus.irq_i = '0; bus.edge_i = '0; bus.ie_i = '0;
    bus.off_we_i = 1'b0; bus.off_idx_i = '0; bus.off_wdata_i = '0;
    bus.claim_i = 1'b0; bus.claim_idx_i = '0;
    bus.complete_i = 1'b0; bus.complete_idx_i = '0;

    rst_n = 1'b0;
    step(); step();
    check("rst_ip", 64'(bus.ip_o), 64'd0);
    check("rst_act", 64'(bus.act_o), 64'd0);
    rst_n = 1'b1;
    bus.ie_i   = '1;
    bus.edge_i = 6'b101110;
    step();

    // Edge trigger on source 2
    wr_off(2, 100);
    mtime = 64'd1000; bus.irq_i[2] = 1'b1;
    step();
    check("edge_ip2", 64'(bus.ip_o[2]), 64'd1);
    check("edge_dl2", dl_of(2), 64'd1100);
    do_claim(2);
    do_complete(2);
    check("edge_done_act2", 64'(bus.act_o[2]), 64'd0);
    step();
    check("edge_hold_no_retrig", 64'(bus.ip_o[2]), 64'd0);
    bus.irq_i[2] = 1'b0; step();
    bus.irq_i[2] = 1'b1; mtime = 64'd1500; step();
    check("edge_retrig_ip2", 64'(bus.ip_o[2]), 64'd1);
    check("edge_retrig_dl2", dl_of(2), 64'd1600);
    do_claim(2); do_complete(2);
    bus.irq_i[2] = 1'b0; step();

    // Level re-trigger on source 0
    wr_off(0, 50);
    bus.irq_i[0] = 1'b1; step();
    do_claim(0);
    mtime = 64'd2000;
    do_complete(0);
    check("lvl_act0", 64'(bus.act_o[0]), 64'd0);
    check("lvl_ip0", 64'(bus.ip_o[0]), 64'd1);
    check("lvl_dl0", dl_of(0), 64'd2050);
    bus.irq_i[0] = 1'b0;
    do_claim(0); do_complete(0);

    // Dropped trigger and ignored handshakes
    bus.irq_i[1] = 1'b1; step();
    do_claim(1);
    bus.irq_i[1] = 1'b0; step();
    bus.irq_i[1] = 1'b1; mtime = 64'd3000; step();
    check("drop_act1", 64'(bus.act_o[1]), 64'd1);
    check("drop_dl1", dl_of(1), 64'd2000);
    do_claim(4);
    check("claim_idle_act4", 64'(bus.act_o[4]), 64'd0);
    do_complete(N);
    check("complete_oor_act1", 64'(bus.act_o[1]), 64'd1);
    bus.irq_i[1] = 1'b0;
    do_complete(1);

    // Offset write racing a trigger on source 3
    wr_off(3, 7);
    bus.off_we_i = 1'b1; bus.off_idx_i = IW'(3); bus.off_wdata_i = OW'(9);
    bus.irq_i[3] = 1'b1; mtime = 64'd10;
    step();
    check("race_dl3", dl_of(3), 64'd17);
    do_claim(3); do_complete(3);
    bus.irq_i[3] = 1'b0; step();
    bus.irq_i[3] = 1'b1; mtime = 64'd20; step();
    check("race_next_dl3", dl_of(3), 64'd29);
    do_claim(3); do_complete(3);
    bus.irq_i[3] = 1'b0; step();

    // Wrap and enable mask on source 5
    wr_off(5, 10);
    mtime = 64'hFFFF_FFFF_FFFF_FFFC; bus.irq_i[5] = 1'b1; step();
    check("wrap_dl5", dl_of(5), 64'd6);
    bus.ie_i[5] = 1'b0; step();
    check("mask_ip5", 64'(bus.ip_o[5]), 64'd0);
    check("mask_dl5", dl_of(5), 64'd6);
    bus.ie_i[5] = 1'b1; step();
    check("unmask_ip5", 64'(bus.ip_o[5]), 64'd1);
    check("unmask_dl5", dl_of(5), 64'd6);
    do_claim(5); do_complete(5);
    bus.irq_i[5] = 1'b0; step();

    // Deadline miss on source 4 (level), dl = 500
    wr_off(4, 100);
    mtime = 64'd400; bus.irq_i[4] = 1'b1; step();
    bus.irq_i[4] = 1'b0;
    check("miss_dl4", dl_of(4), 64'd500);
    mtime = 64'd499; step();
`ifdef EDF_GW_DL_MISS_EN
    check("miss_499", 64'(bus.dl_miss_o[4]), 64'd0);
`endif
    mtime = 64'd500; step();
`ifdef EDF_GW_DL_MISS_EN
    check("miss_500", 64'(bus.dl_miss_o[4]), 64'd1);
`endif
    mtime = 64'd100; step();
`ifdef EDF_GW_DL_MISS_EN
    check("miss_sticky", 64'(bus.dl_miss_o[4]), 64'd1);
`endif

    // Synchronous reset mid-operation
    rst_n = 1'b0; step();
    check("rst2_ip", 64'(bus.ip_o), 64'd0);
    check("rst2_act", 64'(bus.act_o), 64'd0);
    check("rst2_dl4", dl_of(4), 64'd0);
`ifdef EDF_GW_DL_MISS_EN
    check("rst2_miss", 64'(bus.dl_miss_o), 64'd0);
`endif
    rst_n = 1'b1;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      bus.irq_i = N'($urandom);
      if ($urandom_range(0, 15) == 0) bus.edge_i = N'($urandom);
      for (int i = 0; i < N; i++) bus.ie_i[i] = ($urandom_range(0, 7) != 0);
      bus.off_we_i    = ($urandom_range(0, 3) == 0);
      bus.off_idx_i   = IW'($urandom_range(0, 7));
      bus.off_wdata_i = OW'($urandom_range(0, 200));
      bus.claim_i     = ($urandom_range(0, 1) == 0);
      bus.claim_idx_i = IW'($urandom_range(0, 7));
      bus.complete_i  = ($urandom_range(0, 2) == 0);
      bus.complete_idx_i = IW'($urandom_range(0, 7));
      if ($urandom_range(0, 250) == 0) mtime = 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(0, 200));
      else mtime = mtime + 64'($urandom_range(0, 40));
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
